// File: rtl/usb_pkg.sv
// Shared USB full-speed line definitions used by the TX encoder and RX decoder.
package usb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StData,
    StStuff,
    StEopSe0,
    StEopJ
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // Line states as {d_plus, d_minus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam int unsigned EOP_SE0_BITS = 2;

  // NRZI: a raw 0 toggles J<->K, a raw 1 holds the current state
  function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic raw);
    if (raw) return line;
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_tx_encoder_if.sv
// Byte-stream handshake between the TX packet FSM (master) and the line encoder (slave).
interface usb_tx_encoder_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_error;

  modport master (
    output tx_valid, tx_data, tx_last,
    input  tx_ready, tx_busy, tx_error
  );

  modport slave (
    input  tx_valid, tx_data, tx_last,
    output tx_ready, tx_busy, tx_error
  );
endinterface

// File: rtl/usb_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and strobes bit_tick_o on the final clock of a bit.
module usb_tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic bit_tick_o
);
  localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TimerW-1:0] CntMax = TimerW'(CLKS_PER_BIT - 1);

  logic [TimerW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || (cnt_q == CntMax)) cnt_d = '0;
  end

  assign bit_tick_o = !clear_i && (cnt_q == CntMax);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit line encoder: SYNC prefix, LSB-first serialiser, bit stuffing,
// NRZI and EOP generation, driving registered D+/D-.
module usb_tx_encoder
  import usb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned STUFF_LIMIT  = 6
) (
  input  logic            clk,
  input  logic            rst,
  usb_tx_encoder_if.slave tx,
  output logic            d_plus,
  output logic            d_minus
);
  localparam logic [2:0] StuffLimit = 3'(STUFF_LIMIT);
  localparam logic       Se0Last    = 1'(EOP_SE0_BITS - 1);

  tx_state_t  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [2:0] ones_q, ones_d;
  logic       last_q, last_d;
  logic       stuff_eob_q, stuff_eob_d;
  logic       se0_cnt_q, se0_cnt_d;
  logic [1:0] line_q, line_d;

  logic       bit_tick, fetch, ready, error;
  logic       send, raw, advance, go_eop;
  logic [2:0] idx_next;

  usb_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_q == StIdle),
    .bit_tick_o(bit_tick)
  );

  assign idx_next = bit_idx_q + 3'd1;

  // Byte boundary where a new byte is needed; a pending stuff bit defers it by one bit.
  always_comb begin
    fetch = 1'b0;
    case (state_q)
      StSync:  fetch = (bit_idx_q == 3'd7);
      StData:  fetch = (bit_idx_q == 3'd7) && !last_q && (ones_q != StuffLimit);
      StStuff: fetch = stuff_eob_q && !last_q;
      default: fetch = 1'b0;
    endcase
  end

  assign ready = bit_tick && fetch;
  assign error = ready && !tx.tx_valid;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    ones_d      = ones_q;
    last_d      = last_q;
    stuff_eob_d = stuff_eob_q;
    se0_cnt_d   = se0_cnt_q;
    line_d      = line_q;
    send        = 1'b0;
    raw         = 1'b0;
    advance     = 1'b0;
    go_eop      = 1'b0;

    case (state_q)
      StIdle: begin
        if (tx.tx_valid) begin
          state_d   = StSync;
          shift_d   = SYNC_BYTE;
          bit_idx_d = '0;
          last_d    = 1'b0;
          send      = 1'b1;
          raw       = SYNC_BYTE[0];
        end
      end
      StSync: advance = bit_tick && !fetch;
      StData: begin
        if (bit_tick) begin
          if (ones_q == StuffLimit) begin
            state_d     = StStuff;
            stuff_eob_d = (bit_idx_q == 3'd7);
            send        = 1'b1;
          end else if (bit_idx_q != 3'd7) begin
            advance = 1'b1;
          end else if (last_q) begin
            go_eop = 1'b1;
          end
        end
      end
      StStuff: begin
        if (bit_tick && !stuff_eob_q) begin
          state_d = StData;
          advance = 1'b1;
        end else if (bit_tick && last_q) begin
          go_eop = 1'b1;
        end
      end
      StEopSe0: begin
        if (bit_tick) begin
          if (se0_cnt_q == Se0Last) begin
            state_d = StEopJ;
            line_d  = LINE_J;
          end else begin
            se0_cnt_d = se0_cnt_q + 1'b1;
          end
        end
      end
      StEopJ: if (bit_tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (ready) begin
      if (tx.tx_valid) begin
        state_d   = StData;
        shift_d   = tx.tx_data;
        last_d    = tx.tx_last;
        bit_idx_d = '0;
        send      = 1'b1;
        raw       = tx.tx_data[0];
      end else begin
        go_eop = 1'b1;
      end
    end

    if (advance) begin
      bit_idx_d = idx_next;
      send      = 1'b1;
      raw       = shift_q[idx_next];
    end

    // Stuff bits are plain raw zeros, so they share this path and clear the run counter.
    if (send) begin
      line_d = nrzi_next(line_q, raw);
      ones_d = raw ? ones_q + 3'd1 : 3'd0;
    end

    if (go_eop) begin
      state_d   = StEopSe0;
      se0_cnt_d = 1'b0;
      line_d    = LINE_SE0;
      ones_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      ones_q      <= '0;
      last_q      <= 1'b0;
      stuff_eob_q <= 1'b0;
      se0_cnt_q   <= 1'b0;
      line_q      <= LINE_J;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      ones_q      <= ones_d;
      last_q      <= last_d;
      stuff_eob_q <= stuff_eob_d;
      se0_cnt_q   <= se0_cnt_d;
      line_q      <= line_d;
    end
  end

  assign tx.tx_ready = ready;
  assign tx.tx_error = error;
  assign tx.tx_busy  = (state_q != StIdle);
  assign d_plus      = line_q[1];
  assign d_minus     = line_q[0];
endmodule
